// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: takes a divider quotient as tuning word, clamps it to Nyquist,
// accumulates phase and emits a registered, offset-adjusted waveform-ROM address.
module dds_phase_accum #(
  parameter int DATA_WIDTH  = 64,
  parameter int ACC_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter bit SYNC_UPDATE = 1'b0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [DATA_WIDTH-1:0] ftw_in,
  input  logic                  ftw_valid,
  output logic                  ftw_ready,
  input  logic [ACC_WIDTH-1:0]  phase_ofs,
  input  logic                  phase_ofs_load,
  input  logic                  enable,
  input  logic                  phase_clr,
  output logic [ACC_WIDTH-1:0]  phase_out,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  addr_valid,
  output logic                  wrap,
  output logic [ACC_WIDTH-1:0]  cur_ftw,
  output logic                  ftw_clamped,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] NYQ_D = DATA_WIDTH'(1) << (ACC_WIDTH - 1);
  localparam logic [ACC_WIDTH-1:0]  NYQ_A = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  phase_q, phase_d;
  logic [ACC_WIDTH-1:0]  ofs_q, ofs_d;
  logic [ACC_WIDTH-1:0]  cur_ftw_q, cur_ftw_d;
  logic [ACC_WIDTH-1:0]  pend_ftw_q, pend_ftw_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  wrap_q, wrap_d;
  logic                  clamped_q, clamped_d;

  logic                  accept;
  logic                  ftw_over;
  logic [ACC_WIDTH-1:0]  ftw_clamp;
  logic [ACC_WIDTH:0]    sum;
  logic [ACC_WIDTH-1:0]  ofs_sum;

  // Handshake: ftw_in is taken at a rising edge where ftw_valid && ftw_ready;
  // ftw_ready drops only while a deferred word waits for the next wrap.
  assign ftw_ready = (state_q != PENDING);
  assign accept    = ftw_valid & ftw_ready;
  assign ftw_over  = (ftw_in > NYQ_D);
  assign ftw_clamp = ftw_over ? NYQ_A : ftw_in[ACC_WIDTH-1:0];
  assign sum       = {1'b0, phase_q} + {1'b0, cur_ftw_q};
  assign ofs_sum   = phase_q + ofs_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    ofs_d        = ofs_q;
    cur_ftw_d    = cur_ftw_q;
    pend_ftw_d   = pend_ftw_q;
    clamped_d    = clamped_q;
    wrap_d       = 1'b0;
    rom_addr_d   = ADDR_WIDTH'(ofs_sum >> (ACC_WIDTH - ADDR_WIDTH));
    addr_valid_d = enable & (state_q != IDLE);

    if (phase_ofs_load) ofs_d = phase_ofs;

    // Clear wins over accumulate; a deferred word is committed either way.
    if (phase_clr) begin
      phase_d = '0;
      if (state_q == PENDING) begin
        cur_ftw_d = pend_ftw_q;
        state_d   = RUN;
      end
    end else if (enable && (state_q != IDLE)) begin
      phase_d = sum[ACC_WIDTH-1:0];
      wrap_d  = sum[ACC_WIDTH];
      if ((state_q == PENDING) && sum[ACC_WIDTH]) begin
        cur_ftw_d = pend_ftw_q;
        state_d   = RUN;
      end
    end

    if (accept) begin
      clamped_d = ftw_over;
      if ((state_q == RUN) && SYNC_UPDATE) begin
        pend_ftw_d = ftw_clamp;
        state_d    = PENDING;
      end else begin
        cur_ftw_d = ftw_clamp;
        state_d   = RUN;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      ofs_q        <= '0;
      cur_ftw_q    <= '0;
      pend_ftw_q   <= '0;
      rom_addr_q   <= '0;
      addr_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      clamped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      ofs_q        <= ofs_d;
      cur_ftw_q    <= cur_ftw_d;
      pend_ftw_q   <= pend_ftw_d;
      rom_addr_q   <= rom_addr_d;
      addr_valid_q <= addr_valid_d;
      wrap_q       <= wrap_d;
      clamped_q    <= clamped_d;
    end
  end

  assign phase_out   = phase_q;
  assign rom_addr    = rom_addr_q;
  assign addr_valid  = addr_valid_q;
  assign wrap        = wrap_q;
  assign cur_ftw     = cur_ftw_q;
  assign ftw_clamped = clamped_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_dds_phase_accum.sv
// Bench for dds_phase_accum: one immediate-update and one phase-continuous instance
// share the stimulus; each scenario task checks the instance it targets.
module tb_dds_phase_accum;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [63:0] ftw_in;
  logic        ftw_valid;
  logic [31:0] phase_ofs;
  logic        phase_ofs_load, enable, phase_clr;

  logic        a_ready, a_av, a_wrap, a_clamped;
  logic [31:0] a_phase, a_cur;
  logic [11:0] a_addr;
  logic [1:0]  a_state;
  logic        b_ready, b_av, b_wrap, b_clamped;
  logic [31:0] b_phase, b_cur;
  logic [11:0] b_addr;
  logic [1:0]  b_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [11:0] exp_addr_q[$];

  always #5 sys_clk = ~sys_clk;

  dds_phase_accum #(.SYNC_UPDATE(1'b0)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ftw_in(ftw_in), .ftw_valid(ftw_valid),
    .ftw_ready(a_ready), .phase_ofs(phase_ofs), .phase_ofs_load(phase_ofs_load),
    .enable(enable), .phase_clr(phase_clr), .phase_out(a_phase), .rom_addr(a_addr),
    .addr_valid(a_av), .wrap(a_wrap), .cur_ftw(a_cur), .ftw_clamped(a_clamped),
    .fsm_state(a_state)
  );

  dds_phase_accum #(.SYNC_UPDATE(1'b1)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ftw_in(ftw_in), .ftw_valid(ftw_valid),
    .ftw_ready(b_ready), .phase_ofs(phase_ofs), .phase_ofs_load(phase_ofs_load),
    .enable(enable), .phase_clr(phase_clr), .phase_out(b_phase), .rom_addr(b_addr),
    .addr_valid(b_av), .wrap(b_wrap), .cur_ftw(b_cur), .ftw_clamped(b_clamped),
    .fsm_state(b_state)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1; ftw_in = '0; ftw_valid = 1'b0; phase_ofs = '0;
    phase_ofs_load = 1'b0; enable = 1'b0; phase_clr = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  function automatic logic [31:0] clamp32(input logic [63:0] x);
    return (x > 64'h8000_0000) ? 32'h8000_0000 : x[31:0];
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++; if (a_phase !== 32'h0) begin failures++; $display("FAIL reset_phase got=%h exp=0", a_phase); end
    checks++; if (a_addr !== 12'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", a_addr); end
    checks++; if (a_av !== 1'b0) begin failures++; $display("FAIL reset_addr_valid got=%b exp=0", a_av); end
    checks++; if (a_wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", a_wrap); end
    checks++; if (a_cur !== 32'h0) begin failures++; $display("FAIL reset_cur_ftw got=%h exp=0", a_cur); end
    checks++; if (a_clamped !== 1'b0) begin failures++; $display("FAIL reset_clamped got=%b exp=0", a_clamped); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
    checks++; if (a_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", a_state); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_sync got=%b exp=1", b_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    ftw_in = 64'd85; ftw_valid = 1'b1; enable = 1'b1;
    tick();
    ftw_valid = 1'b0;
    checks++; if (a_cur !== 32'd85) begin failures++; $display("FAIL basic_cur_ftw got=%0d exp=85", a_cur); end
    checks++; if (a_clamped !== 1'b0) begin failures++; $display("FAIL basic_clamped got=%b exp=0", a_clamped); end
    checks++; if (a_phase !== 32'h0) begin failures++; $display("FAIL basic_first_phase got=%0d exp=0", a_phase); end
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(32'(85 * k));
      tick();
      e = exp_q.pop_front();
      checks++; if (a_phase !== e) begin failures++; $display("FAIL basic_phase k=%0d got=%0d exp=%0d", k, a_phase, e); end
      checks++; if (a_addr !== 12'h0) begin failures++; $display("FAIL basic_addr k=%0d got=%h exp=0", k, a_addr); end
      checks++; if (a_av !== 1'b1) begin failures++; $display("FAIL basic_addr_valid k=%0d got=%b exp=1", k, a_av); end
    end
  endtask

  task automatic test_quarter();
    logic [31:0] p, e;
    logic [11:0] ea;
    apply_reset();
    ftw_in = 64'h4000_0000; ftw_valid = 1'b1; enable = 1'b1;
    tick();
    ftw_valid = 1'b0;
    p = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      exp_addr_q.push_back(p[31:20]);
      p = p + 32'h4000_0000;
      exp_q.push_back(p);
      tick();
      e  = exp_q.pop_front();
      ea = exp_addr_q.pop_front();
      checks++; if (a_phase !== e) begin failures++; $display("FAIL quarter_phase k=%0d got=%h exp=%h", k, a_phase, e); end
      checks++; if (a_addr !== ea) begin failures++; $display("FAIL quarter_addr k=%0d got=%h exp=%h", k, a_addr, ea); end
      checks++; if (a_wrap !== ((k % 4) == 0)) begin failures++; $display("FAIL quarter_wrap k=%0d got=%b exp=%b", k, a_wrap, (k % 4) == 0); end
    end
  endtask

  task automatic test_clamp();
    logic [63:0] words[5]  = '{64'h1_0000_0000, 64'd100, 64'h8000_0000, 64'h8000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [31:0] cur_e[5]  = '{32'h8000_0000, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic        clamp_e[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      ftw_in = words[i]; ftw_valid = 1'b1;
      tick();
      checks++; if (a_cur !== cur_e[i]) begin failures++; $display("FAIL clamp_cur i=%0d got=%h exp=%h", i, a_cur, cur_e[i]); end
      checks++; if (a_clamped !== clamp_e[i]) begin failures++; $display("FAIL clamp_flag i=%0d got=%b exp=%b", i, a_clamped, clamp_e[i]); end
    end
    ftw_valid = 1'b0;
  endtask

  task automatic test_sync();
    logic [3:0]  ph_nib[11] = '{4'h4, 4'h8, 4'hC, 4'h0, 4'h4, 4'h8, 4'hC, 4'h0, 4'h8, 4'h0, 4'h8};
    logic        rdy_e[11]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        wrp_e[11]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] e, ce;
    apply_reset();
    ftw_in = 64'h4000_0000; ftw_valid = 1'b1; enable = 1'b1;
    tick();
    ftw_valid = 1'b0;
    checks++; if (b_cur !== 32'h4000_0000) begin failures++; $display("FAIL sync_first_load got=%h exp=40000000", b_cur); end
    for (int k = 1; k <= 11; k++) begin
      if (k == 5) begin ftw_in = 64'h8000_0000; ftw_valid = 1'b1; end
      exp_q.push_back({ph_nib[k-1], 28'h0});
      tick();
      ftw_valid = 1'b0;
      e  = exp_q.pop_front();
      ce = (k >= 8) ? 32'h8000_0000 : 32'h4000_0000;
      checks++; if (b_phase !== e) begin failures++; $display("FAIL sync_phase k=%0d got=%h exp=%h", k, b_phase, e); end
      checks++; if (b_ready !== rdy_e[k-1]) begin failures++; $display("FAIL sync_ready k=%0d got=%b exp=%b", k, b_ready, rdy_e[k-1]); end
      checks++; if (b_cur !== ce) begin failures++; $display("FAIL sync_cur_ftw k=%0d got=%h exp=%h", k, b_cur, ce); end
      checks++; if (b_wrap !== wrp_e[k-1]) begin failures++; $display("FAIL sync_wrap k=%0d got=%b exp=%b", k, b_wrap, wrp_e[k-1]); end
    end
  endtask

  task automatic test_clr_ofs();
    apply_reset();
    ftw_in = 64'h4000_0000; ftw_valid = 1'b1; enable = 1'b1;
    tick();
    ftw_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (a_phase !== 32'hC000_0000) begin failures++; $display("FAIL clr_pre_phase got=%h exp=c0000000", a_phase); end
    phase_clr = 1'b1; ftw_in = 64'h1000_0000; ftw_valid = 1'b1;
    tick();
    phase_clr = 1'b0; ftw_valid = 1'b0;
    checks++; if (a_phase !== 32'h0) begin failures++; $display("FAIL clr_phase got=%h exp=0", a_phase); end
    checks++; if (a_wrap !== 1'b0) begin failures++; $display("FAIL clr_wrap got=%b exp=0", a_wrap); end
    checks++; if (a_cur !== 32'h1000_0000) begin failures++; $display("FAIL clr_cur_ftw got=%h exp=10000000", a_cur); end
    tick();
    checks++; if (a_phase !== 32'h1000_0000) begin failures++; $display("FAIL clr_post_phase got=%h exp=10000000", a_phase); end
    phase_ofs = 32'h8000_0000; phase_ofs_load = 1'b1;
    tick();
    phase_ofs_load = 1'b0;
    checks++; if (a_addr !== 12'h100) begin failures++; $display("FAIL ofs_load_edge_addr got=%h exp=100", a_addr); end
    tick();
    checks++; if (a_addr !== 12'hA00) begin failures++; $display("FAIL ofs_addr1 got=%h exp=a00", a_addr); end
    tick();
    checks++; if (a_addr !== 12'hB00) begin failures++; $display("FAIL ofs_addr2 got=%h exp=b00", a_addr); end
  endtask

  task automatic test_reset_pending();
    apply_reset();
    ftw_in = 64'h4000_0000; ftw_valid = 1'b1; enable = 1'b1;
    tick();
    ftw_in = 64'h8000_0000;
    tick();
    ftw_valid = 1'b0;
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL pend_ready got=%b exp=0", b_ready); end
    checks++; if (b_state !== 2'd2) begin failures++; $display("FAIL pend_state got=%0d exp=2", b_state); end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    checks++; if (b_phase !== 32'h0) begin failures++; $display("FAIL rstpend_phase got=%h exp=0", b_phase); end
    checks++; if (b_cur !== 32'h0) begin failures++; $display("FAIL rstpend_cur got=%h exp=0", b_cur); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL rstpend_ready got=%b exp=1", b_ready); end
    checks++; if (b_av !== 1'b0) begin failures++; $display("FAIL rstpend_addr_valid got=%b exp=0", b_av); end
    checks++; if ({b_wrap, b_clamped, b_addr} !== 14'h0) begin failures++; $display("FAIL rstpend_misc got=%h exp=0", {b_wrap, b_clamped, b_addr}); end
    ftw_in = 64'h123; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    checks++; if (b_cur !== 32'h123) begin failures++; $display("FAIL rstpend_reload got=%h exp=123", b_cur); end
    checks++; if (b_state !== 2'd1) begin failures++; $display("FAIL rstpend_state got=%0d exp=1", b_state); end
  endtask

  task automatic test_zero_ftw();
    apply_reset();
    ftw_in = 64'h0; ftw_valid = 1'b1; enable = 1'b1;
    tick();
    ftw_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (a_phase !== 32'h0) begin failures++; $display("FAIL zero_phase k=%0d got=%h exp=0", k, a_phase); end
      checks++; if (a_wrap !== 1'b0) begin failures++; $display("FAIL zero_wrap k=%0d got=%b exp=0", k, a_wrap); end
      checks++; if (a_av !== 1'b1) begin failures++; $display("FAIL zero_addr_valid k=%0d got=%b exp=1", k, a_av); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] m_ph, m_cur, e;
    logic        m_run;
    apply_reset();
    enable = 1'b1;
    m_ph = '0; m_cur = '0; m_run = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ftw_in    = {31'h0, 1'($urandom_range(0, 1)), 32'($urandom)};
      ftw_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_run) m_ph = m_ph + m_cur;
      if (ftw_valid) begin m_cur = clamp32(ftw_in); m_run = 1'b1; end
      exp_q.push_back(m_ph);
      tick();
      e = exp_q.pop_front();
      checks++; if (a_phase !== e) begin failures++; $display("FAIL b2b_phase i=%0d got=%h exp=%h", i, a_phase, e); end
      checks++; if (a_cur !== m_cur) begin failures++; $display("FAIL b2b_cur i=%0d got=%h exp=%h", i, a_cur, m_cur); end
    end
    ftw_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_quarter();
    test_clamp();
    test_sync();
    test_clr_ofs();
    test_reset_pending();
    test_zero_ftw();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dds_phase_accum.md
Name: dds_phase_accum

Overview:
Phase accumulator stage sitting directly downstream of the 64/64 frequency-tuning-word divider (quotient = (2^32-1)/f_clk × f_out). Accepts the divider quotient through a valid/ready handshake, clamps it to the accumulator range and accumulates phase every enabled cycle. Produces a registered, offset-adjusted waveform-ROM address. Supports immediate or phase-continuous (commit-at-wrap) tuning-word updates.

Parameters:
DATA_WIDTH, 64, width of the incoming tuning word (divider quotient width)
ACC_WIDTH, 32, phase accumulator width
ADDR_WIDTH, 12, ROM address width; top ADDR_WIDTH bits of the phase
SYNC_UPDATE, 0, 0 = new FTW applied immediately; 1 = new FTW deferred to the next accumulator wrap

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
ftw_in  in  DATA_WIDTH  tuning word (divider quotient_sig)
ftw_valid  in  1  ftw_in valid
ftw_ready  out  1  block can accept ftw_in
phase_ofs  in  ACC_WIDTH  phase offset value
phase_ofs_load  in  1  latch phase_ofs into offset register
enable  in  1  accumulate when high
phase_clr  in  1  zero the accumulator
phase_out  out  ACC_WIDTH  current accumulator value
rom_addr  out  ADDR_WIDTH  waveform ROM address
addr_valid  out  1  rom_addr valid
wrap  out  1  one-cycle pulse on accumulator carry-out
cur_ftw  out  ACC_WIDTH  tuning word in use
ftw_clamped  out  1  last accepted FTW was clamped

Behaviour:
- Reset: phase_acc, offset reg, cur_ftw, pend_ftw, rom_addr, addr_valid, wrap, ftw_clamped = 0. State IDLE. ftw_ready = 1.
- States:
  - IDLE: no FTW loaded yet.
  - RUN: FTW loaded, accumulating.
  - PENDING: only when SYNC_UPDATE=1; new FTW waiting for wrap.
- ftw_ready = 1 in IDLE/RUN, 0 in PENDING (combinational from state). Accept = ftw_valid & ftw_ready at an edge.
- Clamp: clamp(x) = x if x ≤ 2^(ACC_WIDTH-1), else 2^(ACC_WIDTH-1) (Nyquist). ftw_clamped is updated on every accept.
- Accept when in IDLE, or in RUN with SYNC_UPDATE=0: cur_ftw <= clamp(ftw_in) at that edge; state -> RUN. The first add using the new word happens at the following edge.
- Accept when in RUN with SYNC_UPDATE=1: pend_ftw <= clamp(ftw_in); state -> PENDING.
- In PENDING, at the edge where an add carries out: the add uses the old cur_ftw, then cur_ftw <= pend_ftw and state -> RUN. If enable=0, the state is held.
- Accumulate: at each edge with enable=1 and state ≠ IDLE, phase_acc <= (phase_acc + cur_ftw) mod 2^ACC_WIDTH, and wrap <= carry-out. Otherwise wrap <= 0.
- phase_clr has priority over accumulate: phase_acc <= 0, wrap <= 0. It does not change cur_ftw. In PENDING it commits pend_ftw and returns to RUN.
- phase_clr and accept on the same edge: both take effect.
- phase_ofs_load: offset reg <= phase_ofs at the edge. The new offset affects rom_addr from the next edge.
- Output path:
  - rom_addr <= (phase_acc + offset)[ACC_WIDTH-1 -: ADDR_WIDTH], registered, so one cycle behind phase_out.
  - addr_valid <= enable & (state ≠ IDLE).
- FTW = 0 is legal: the accumulator holds and wrap never pulses.
- Reset mid-operation (including PENDING): everything returns to reset values and the pending word is discarded.

Test Plan:
1. Reset, then accept ftw_in=85 (= (2^32-1)/50_000_000), enable=1 -> cur_ftw=85; phase_out=85,170,255… on successive edges; rom_addr=0; ftw_clamped=0.
2. ftw_in=2^30, offset 0 -> phase_out cycles 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0; rom_addr 0x400, 0x800, 0xC00, 0x000 one cycle later; wrap pulses every 4th edge.
3. ftw_in=64'h1_0000_0000 -> cur_ftw=0x8000_0000, ftw_clamped=1; a following accept of 100 -> ftw_clamped=0.
4. SYNC_UPDATE=1: running 2^30, offer 2^31 one edge after a wrap -> ftw_ready=0 for 3 cycles; cur_ftw changes on the wrap edge; the sequence continues phase-continuously.
5. phase_clr with enable=1 and ftw_valid on the same edge -> phase_out=0, no wrap, new FTW loaded. Load phase_ofs=0x8000_0000 -> rom_addr offset by 0x800.
6. Assert sys_rst while PENDING -> all outputs 0, ftw_ready=1, addr_valid=0; the next accept loads immediately.
